// File: rtl/eth_phy_mdio_ctrl.sv
// Management controller for an external 88E1111-class PHY. It sequences the hardware reset,
// writes the control register over clause-22 MDIO, then polls the status register.
module eth_phy_mdio_ctrl #(
    parameter logic [4:0]  PHY_ADDR     = 5'd7,
    parameter int unsigned MDC_DIV      = 50,
    parameter int unsigned RESET_CYCLES = 1250000,
    parameter int unsigned POLL_CYCLES  = 12500000,
    parameter logic [15:0] CTRL_VALUE   = 16'h9140
) (
    input  logic       clock125,
    input  logic       reset,
    input  logic       restart,
    output logic       phy_reset_n,
    output logic       mdio_mdc,
    output logic       mdio_o,
    output logic       mdio_t,
    input  logic       mdio_i,
    output logic       init_done,
    output logic       busy,
    output logic       link_up,
    output logic [1:0] speed,
    output logic       duplex,
    output logic       phy_error
);
    // state     | meaning
    // RST_HOLD  | phy_reset_n held low
    // RST_WAIT  | phy_reset_n released, settling
    // CFG_WR    | control register write frame
    // POLL_WAIT | idle gap between status polls
    // POLL_RD   | status register read frame
    typedef enum logic [2:0] {RST_HOLD, RST_WAIT, CFG_WR, POLL_WAIT, POLL_RD} state_t;

    localparam logic [7:0]  DIV_TC    = 8'(MDC_DIV - 1);
    localparam logic [31:0] RST_LOAD  = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] POLL_LOAD = 32'(POLL_CYCLES - 1);
    localparam logic [63:0] WR_FRAME  = {32'hFFFF_FFFF, 2'b01, 2'b01, PHY_ADDR, 5'h00, 2'b10, CTRL_VALUE};
    localparam logic [63:0] RD_FRAME  = {32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, 5'h11, 2'b11, 16'hFFFF};

    state_t      state_q, state_d;
    logic [31:0] tmr_q, tmr_d;
    logic [7:0]  div_q, div_d;
    logic [5:0]  bit_q, bit_d;
    logic [62:0] tx_q, tx_d;
    logic        mdc_q, mdc_d, mdo_q, mdo_d, mdt_q, mdt_d, busy_q, busy_d;
    logic        rd_q, rd_d, pend_q, pend_d, upd_q, upd_d, ta_err_q, ta_err_d;
    logic [1:0]  spd_rx_q, spd_rx_d, lnk_rx_q, lnk_rx_d;
    logic        dup_rx_q, dup_rx_d;
    logic        phy_rst_n_q, phy_rst_n_d, init_done_q, init_done_d;
    logic        link_q, link_d, duplex_q, duplex_d, err_q, err_d;
    logic [1:0]  speed_q, speed_d;

    logic div_tc, mdc_rise, mdc_fall, frame_end, tmr_tc, idle_st, act, start_wr, start_rd;

    assign div_tc    = busy_q && (div_q == DIV_TC);
    assign mdc_rise  = div_tc && !mdc_q;
    assign mdc_fall  = div_tc && mdc_q;
    assign frame_end = mdc_fall && (bit_q == 6'd63);
    assign tmr_tc    = (tmr_q == 32'd0);
    assign idle_st   = (state_q == RST_HOLD) || (state_q == RST_WAIT) || (state_q == POLL_WAIT);
    // A pending restart waits for the frame boundary so a frame is never cut short.
    assign act       = pend_q && (idle_st || frame_end);
    assign start_wr  = (state_q == RST_WAIT) && tmr_tc && !act;
    assign start_rd  = (state_q == POLL_WAIT) && tmr_tc && !act;

    always_ff @(posedge clock125 or posedge reset) begin
        if (reset) state_q <= RST_HOLD;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (act) begin
            state_d = RST_HOLD;
        end else begin
            case (state_q)
                RST_HOLD:  if (tmr_tc)    state_d = RST_WAIT;
                RST_WAIT:  if (tmr_tc)    state_d = CFG_WR;
                CFG_WR:    if (frame_end) state_d = POLL_WAIT;
                POLL_WAIT: if (tmr_tc)    state_d = POLL_RD;
                POLL_RD:   if (frame_end) state_d = POLL_WAIT;
                default:                  state_d = RST_HOLD;
            endcase
        end
    end

    always_comb begin
        tmr_d = tmr_q; div_d = div_q; bit_d = bit_q; tx_d = tx_q;
        mdc_d = mdc_q; mdo_d = mdo_q; mdt_d = mdt_q; busy_d = busy_q;
        rd_d = rd_q; upd_d = 1'b0; ta_err_d = ta_err_q;
        spd_rx_d = spd_rx_q; dup_rx_d = dup_rx_q; lnk_rx_d = lnk_rx_q;
        phy_rst_n_d = phy_rst_n_q; init_done_d = init_done_q;
        link_d = link_q; speed_d = speed_q; duplex_d = duplex_q; err_d = err_q;
        pend_d = restart | (pend_q & ~act);

        case (state_q)
            RST_HOLD: begin
                if (tmr_tc) begin
                    tmr_d       = RST_LOAD;
                    phy_rst_n_d = 1'b1;
                end else begin
                    tmr_d = tmr_q - 32'd1;
                end
            end
            RST_WAIT, POLL_WAIT: if (!tmr_tc) tmr_d = tmr_q - 32'd1;
            default:             if (frame_end) tmr_d = POLL_LOAD;
        endcase

        if (start_wr || start_rd) begin
            busy_d = 1'b1; div_d = 8'd0; mdc_d = 1'b0; bit_d = 6'd0;
            rd_d   = start_rd;
            tx_d   = start_rd ? RD_FRAME[62:0] : WR_FRAME[62:0];
            mdo_d  = WR_FRAME[63];
            mdt_d  = 1'b0;
        end

        if (busy_q) begin
            div_d = div_tc ? 8'd0 : div_q + 8'd1;
            if (div_tc) mdc_d = ~mdc_q;
        end

        // Only the status fields actually published are captured from the read data.
        if (mdc_rise && rd_q) begin
            case (bit_q)
                6'd47: ta_err_d    = mdio_i;
                6'd48: spd_rx_d[1] = mdio_i;
                6'd49: spd_rx_d[0] = mdio_i;
                6'd50: dup_rx_d    = mdio_i;
                6'd52: lnk_rx_d[1] = mdio_i;
                6'd53: lnk_rx_d[0] = mdio_i;
                6'd63: upd_d       = 1'b1;
                default: ;
            endcase
        end

        if (mdc_fall) begin
            if (bit_q == 6'd63) begin
                busy_d = 1'b0; mdc_d = 1'b0; mdo_d = 1'b1; mdt_d = 1'b1;
                if (state_q == CFG_WR) init_done_d = 1'b1;
            end else begin
                bit_d = bit_q + 6'd1;
                tx_d  = {tx_q[61:0], 1'b0};
                mdo_d = tx_q[62];
                mdt_d = rd_q && (bit_q >= 6'd45);
            end
        end

        if (upd_q) begin
            if (ta_err_q) begin
                err_d  = 1'b1;
                link_d = 1'b0;
            end else begin
                err_d    = 1'b0;
                link_d   = &lnk_rx_q;
                speed_d  = (&spd_rx_q) ? 2'b00 : spd_rx_q;
                duplex_d = dup_rx_q;
            end
        end

        if (act) begin
            tmr_d = RST_LOAD; phy_rst_n_d = 1'b0; init_done_d = 1'b0;
            link_d = 1'b0; err_d = 1'b0;
        end
    end

    always_ff @(posedge clock125 or posedge reset) begin
        if (reset) begin
            tmr_q <= RST_LOAD; div_q <= 8'd0; bit_q <= 6'd0; tx_q <= '0;
            mdc_q <= 1'b0; mdo_q <= 1'b1; mdt_q <= 1'b1; busy_q <= 1'b0;
            rd_q <= 1'b0; pend_q <= 1'b0; upd_q <= 1'b0; ta_err_q <= 1'b0;
            spd_rx_q <= 2'b00; dup_rx_q <= 1'b0; lnk_rx_q <= 2'b00;
            phy_rst_n_q <= 1'b0; init_done_q <= 1'b0;
            link_q <= 1'b0; speed_q <= 2'b00; duplex_q <= 1'b0; err_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d; div_q <= div_d; bit_q <= bit_d; tx_q <= tx_d;
            mdc_q <= mdc_d; mdo_q <= mdo_d; mdt_q <= mdt_d; busy_q <= busy_d;
            rd_q <= rd_d; pend_q <= pend_d; upd_q <= upd_d; ta_err_q <= ta_err_d;
            spd_rx_q <= spd_rx_d; dup_rx_q <= dup_rx_d; lnk_rx_q <= lnk_rx_d;
            phy_rst_n_q <= phy_rst_n_d; init_done_q <= init_done_d;
            link_q <= link_d; speed_q <= speed_d; duplex_q <= duplex_d; err_q <= err_d;
        end
    end

    assign phy_reset_n = phy_rst_n_q;
    assign mdio_mdc    = mdc_q;
    assign mdio_o      = mdo_q;
    assign mdio_t      = mdt_q;
    assign init_done   = init_done_q;
    assign busy        = busy_q;
    assign link_up     = link_q;
    assign speed       = speed_q;
    assign duplex      = duplex_q;
    assign phy_error   = err_q;

endmodule

// File: doc/eth_phy_mdio_ctrl.md
Name: eth_phy_mdio_ctrl

Overview:
- Management-plane controller for the 1G GMII Ethernet path's external PHY (Marvell 88E1111).
- Runs the PHY hardware reset sequence and writes the control register over MDIO (clause 22).
- Then periodically polls the PHY-specific status register and publishes link, speed and duplex to the rest of the design.
- Sits beside the GMII MAC in the clock125 domain; MDC/MDIO/phy_reset_n go to board pins.

Parameters:
- PHY_ADDR, 5'd7, MDIO PHY address.
- MDC_DIV, 50, clock125 cycles per MDC half-period (default gives 1.25 MHz MDC); legal 2..255.
- RESET_CYCLES, 1250000, cycles phy_reset_n is held low, and also cycles waited after release (10 ms each).
- POLL_CYCLES, 12500000, idle cycles between status polls (100 ms); counted from the end of the previous frame.
- CTRL_VALUE, 16'h9140, value written to reg 0 (soft reset, autoneg enable, 1000/full).

Ports:
- clock125  input  1  system clock, 125 MHz.
- reset  input  1  asynchronous, active-high reset.
- restart  input  1  single-cycle pulse; rerun the full init sequence.
- phy_reset_n  output  1  PHY hardware reset, active low.
- mdio_mdc  output  1  MDC clock.
- mdio_o  output  1  MDIO output data.
- mdio_t  output  1  MDIO tristate control; 1 = released/input.
- mdio_i  input  1  MDIO input data from pad.
- init_done  output  1  config write completed.
- busy  output  1  MDIO frame in progress.
- link_up  output  1  link up and speed/duplex resolved.
- speed  output  2  00 = 10M, 01 = 100M, 10 = 1000M.
- duplex  output  1  1 = full duplex.
- phy_error  output  1  last read got no turnaround response.

Behaviour:
- Reset values (async, immediate, including mid-frame): phy_reset_n=0, mdio_mdc=0, mdio_o=1, mdio_t=1, init_done=0, busy=0, link_up=0, speed=00, duplex=0, phy_error=0. FSM goes to RST_HOLD with counters cleared.
- MDC generation:
  - Divider counts 0..MDC_DIV-1 and toggles MDC at terminal count, only while busy; MDC idles low.
  - The shift register updates mdio_o/mdio_t on the clock where MDC goes high→low.
  - mdio_i is sampled on the clock where MDC goes low→high.
  - Each bit occupies one full MDC period; the first bit is driven at frame start, before the first rising edge.
- Frame (64 bits):
  - 32 preamble 1s, ST=01, OP (01 write / 10 read), PHYAD[4:0], REGAD[4:0], TA, DATA[15:0], MSB first.
  - Write frame: TA=10, then data driven; mdio_t=0 for all 64 bits.
  - Read frame: mdio_t=1 from the first TA bit to frame end. The second TA bit is sampled and must be 0. The 16 data bits are shifted in.
  - After the last bit: mdio_t=1, mdio_o=1, MDC held low, busy=0 the following cycle.
- FSM:
  - RST_HOLD: phy_reset_n=0 for RESET_CYCLES, then → RST_WAIT.
  - RST_WAIT: phy_reset_n=1 for RESET_CYCLES, then → CFG_WR.
  - CFG_WR: write CTRL_VALUE to reg 0. At frame end: init_done=1, → POLL_WAIT.
  - POLL_WAIT: count POLL_CYCLES, then → POLL_RD. The first poll occurs after a full POLL_CYCLES delay.
  - POLL_RD: read reg 17 (5'h11). At frame end → POLL_WAIT. Status update is registered the cycle after the last sample:
    - TA ok: phy_error=0, link_up=d[10]&d[11], speed=d[15:14] (11 maps to 00), duplex=d[13].
    - TA bad (second TA bit sampled 1): phy_error=1, link_up=0; speed and duplex hold.
- restart:
  - Latched when pulsed. Acted on at the next frame boundary; a frame in flight is never truncated.
  - In RST_HOLD, RST_WAIT or POLL_WAIT it acts on the next cycle.
  - On action: → RST_HOLD with counters cleared, init_done=0, link_up=0, phy_error=0.
  - A pulse while already in RST_HOLD restarts the hold count.
  - Multiple pulses before action collapse to one.
- Busy covers first driven bit through last bit. Outputs only change at the points above. No combinational path from mdio_i to any output.

Test Plan:
- Reset timing (MDC_DIV=2, RESET_CYCLES=16, POLL_CYCLES=100): release reset → phy_reset_n low exactly 16 cycles, high 16 cycles, then busy=1; MDC period 4 cycles.
- Config write: capture mdio_o on MDC rising edges → 32×1, 01, 01, 00111, 00000, 10, 16'h9140; mdio_t=0 throughout; init_done=1 after frame; no MDC edges while idle.
- Status read with PHY model returning 16'hAC00 and TA=0: opcode 10, reg 10001, mdio_t=1 from TA → link_up=1, speed=10, duplex=1, phy_error=0. Next poll returns 16'h0000 → link_up=0, speed=00, duplex=0.
- No responder (mdio_i tied 1): after a read → phy_error=1, link_up=0, speed/duplex hold previous values; the following poll still issues.
- restart pulsed mid read frame: frame completes all 64 bits, then phy_reset_n=0 the next cycle, init_done=0, link_up=0; full sequence repeats.
- Async reset asserted mid write frame: all outputs take reset values with no clock edge; after release, the sequence restarts from RST_HOLD.
